wr_ptr_full: RTL

WR_PTR_FULL -- requirements
Module: wr_ptr_full

---
 rtl/wr_ptr_full.sv | 88 ++++++++
 1 files changed

// File: rtl/wr_ptr_full.sv
// Write-side pointer and full-flag logic for an asynchronous FIFO.
// Keeps a binary write pointer, publishes its Gray-coded form to the read
// domain, and derives full/almost_full/fill level from the synchronized
// Gray read pointer. All outputs are registered.
module wr_ptr_full #(
  parameter int addr_range = 3,
  parameter int AF_LEVEL   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [addr_range:0]   rd_ptr_sync,
  output logic [addr_range-1:0] wr_addr,
  output logic [addr_range:0]   wr_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [addr_range:0]   wr_count,
  output logic                  wr_ack,
  output logic                  overflow
);

  localparam int PW = addr_range + 1;
  localparam logic [addr_range:0] AF_THR = PW'(AF_LEVEL);

  logic [addr_range:0] r_wbin;
  logic [addr_range:0] r_wptr;
  logic                r_full;
  logic                r_af;
  logic [addr_range:0] r_count;
  logic                r_ack;
  logic                r_ovf;

  logic                w_push;
  logic [addr_range:0] w_wbin_next;
  logic [addr_range:0] w_wgray_next;
  logic [addr_range:0] w_full_cmp;
  logic [addr_range:0] w_rbin;
  logic [addr_range:0] w_count_next;

  // Next-state pointer arithmetic; full is taken from the register so a
  // write in the same cycle as a read advance is still rejected when full.
  always_comb begin
    w_push       = wr_en & ~r_full;
    w_wbin_next  = r_wbin + {{addr_range{1'b0}}, w_push};
    w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    w_full_cmp   = {~rd_ptr_sync[addr_range:addr_range-1], rd_ptr_sync[addr_range-2:0]};
    w_count_next = w_wbin_next - w_rbin;
  end

  // Gray-to-binary of the read pointer: each binary bit is the XOR of all
  // Gray bits at and above it, which unrolls the MSB-down chain.
  always_comb begin
    w_rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      w_rbin[i] = ^(rd_ptr_sync >> i);
    end
  end

  // Register pointer, flags and fill level; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbin  <= '0;
      r_wptr  <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_count <= '0;
      r_ack   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wptr  <= w_wgray_next;
      r_full  <= (w_wgray_next == w_full_cmp);
      r_af    <= (w_count_next >= AF_THR);
      r_count <= w_count_next;
      r_ack   <= w_push;
      r_ovf   <= wr_en & r_full;
    end
  end

  assign wr_addr     = r_wbin[addr_range-1:0];
  assign wr_ptr      = r_wptr;
  assign full        = r_full;
  assign almost_full = r_af;
  assign wr_count    = r_count;
  assign wr_ack      = r_ack;
  assign overflow    = r_ovf;

endmodule
